// File: rtl/sd_pkg.sv
// Shared types and constants for the SD-card CMD-line logic.
// Used by the response receiver and by the command transmitter.
package sd_pkg;

  typedef enum logic [1:0] {
    SD_RX_IDLE,
    SD_RX_WAIT_START,
    SD_RX_RECV,
    SD_RX_DONE
  } sd_rx_state_t;

  localparam logic [6:0] SD_CRC7_POLY = 7'h09;
  localparam int         SD_R1_BITS   = 48;
  localparam int         SD_R2_BITS   = 136;

endpackage

// File: rtl/sd_crc7.sv
// Serial MSB-first CRC7 (x^7 + x^3 + 1), initial value 0.
// Shared between the command transmitter and the response receiver.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic       feedback;

  always_comb begin
    feedback = bit_in ^ crc_q[6];
    crc_d    = {crc_q[5:0], 1'b0} ^ (feedback ? SD_CRC7_POLY : 7'h00);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc_q <= 7'h00;
    end else if (clear) begin
      crc_q <= 7'h00;
    end else if (enable) begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_resp_rx.sv
// SD CMD-line response receiver: waits for the start bit, shifts the frame
// in MSB-first, checks CRC7 and the end bit, and reports valid/timeout.
module sd_cmd_resp_rx
  import sd_pkg::*;
#(
  parameter int RESP_BITS    = SD_R1_BITS,
  parameter int TIMEOUT_BITS = 64,
  parameter int CHECK_CRC    = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 sample_en,
  input  logic                 cmd_in,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic [RESP_BITS-1:0] resp_data,
  output logic                 resp_valid,
  output logic                 crc_err,
  output logic                 end_err,
  output logic                 timeout
);

  localparam int CNT_W = $clog2(RESP_BITS + 1);
  localparam int TO_W  = $clog2(TIMEOUT_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_BITS - 1);
  // CRC covers frame bits [RESP_BITS-1:8]: the first RESP_BITS-8 bits received.
  localparam logic [CNT_W-1:0] CNT_FEED = CNT_W'(RESP_BITS - 8);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_BITS - 1);

  sd_rx_state_t         state_q, state_d;
  logic [RESP_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 crc_err_q, crc_err_d;
  logic                 end_err_q, end_err_d;
  logic                 timeout_q, timeout_d;
  logic                 crc_clear;
  logic                 crc_enable;
  logic [6:0]           crc_value;

  sd_crc7 u_crc7 (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (crc_clear),
    .enable (crc_enable),
    .bit_in (cmd_in),
    .crc    (crc_value)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    to_cnt_d   = to_cnt_q;
    crc_err_d  = crc_err_q;
    end_err_d  = end_err_q;
    timeout_d  = 1'b0;
    crc_clear  = 1'b0;
    crc_enable = 1'b0;

    if (abort) begin
      state_d = SD_RX_IDLE;
    end else begin
      case (state_q)
        SD_RX_IDLE: begin
          bit_cnt_d = '0;
          to_cnt_d  = '0;
          crc_clear = 1'b1;
          // Error flags stay visible to the command FSM until it arms again.
          if (start) begin
            state_d   = SD_RX_WAIT_START;
            crc_err_d = 1'b0;
            end_err_d = 1'b0;
          end
        end

        SD_RX_WAIT_START: begin
          if (sample_en) begin
            if (!cmd_in) begin
              shift_d    = {shift_q[RESP_BITS-2:0], 1'b0};
              crc_enable = 1'b1;
              bit_cnt_d  = CNT_W'(1);
              state_d    = SD_RX_RECV;
            end else begin
              to_cnt_d = to_cnt_q + 1'b1;
              if (to_cnt_q == TO_LAST) begin
                timeout_d = 1'b1;
                state_d   = SD_RX_IDLE;
              end
            end
          end
        end

        SD_RX_RECV: begin
          if (sample_en) begin
            shift_d    = {shift_q[RESP_BITS-2:0], cmd_in};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            crc_enable = (bit_cnt_q < CNT_FEED);
            if (bit_cnt_q == CNT_LAST) begin
              state_d   = SD_RX_DONE;
              crc_err_d = (CHECK_CRC != 0) && (crc_value != shift_d[7:1]);
              end_err_d = !cmd_in;
            end
          end
        end

        SD_RX_DONE: begin
          state_d = SD_RX_IDLE;
        end

        default: begin
          state_d = SD_RX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= SD_RX_IDLE;
      shift_q   <= '1;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      crc_err_q <= crc_err_d;
      end_err_q <= end_err_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy       = (state_q != SD_RX_IDLE);
  assign resp_valid = (state_q == SD_RX_DONE);
  assign resp_data  = shift_q;
  assign crc_err    = crc_err_q;
  assign end_err    = end_err_q;
  assign timeout    = timeout_q;

endmodule
